data_mem_lsu: RTL and testbench

//  Parametrised RV32I data memory with integrated load/store unit: byte/half/word access

---
 rtl/data_mem_lsu.sv | 166 ++++++++++++++++
 tb/tb_data_mem_lsu.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// RV32I data memory with an integrated load/store unit.
// Byte/half/word access by funct3, load extension, misalignment and range faults.
// req/ready acceptance, programmable wait states, one-cycle rvalid response strobe.
module data_mem_lsu #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  err_o
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    // Last counter value spent in WAIT before moving on to RESP.
    localparam logic [3:0] LAST_CNT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              wait_cnt;
    logic                    we_q;
    logic [2:0]              f3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

    // Effective access: live inputs in IDLE (so WAIT_STATES=0 can commit on the
    // acceptance edge), captured copy afterwards.
    logic                    a_we;
    logic [2:0]              a_f3;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [DATA_WIDTH-1:0]   a_data;
    logic [IDX_W-1:0]        idx;
    logic [1:0]              lane;
    logic [ADDR_WIDTH-1:0]   upper;
    logic                    fault;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wword;
    logic [DATA_WIDTH-1:0]   rword;
    logic [7:0]              rbyte;
    logic [15:0]             rhalf;
    logic [DATA_WIDTH-1:0]   ldata;
    logic                    enter_resp;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        rvalid_o  = 1'b0;
        case (state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (req_i) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: if (wait_cnt == LAST_CNT) state_nxt = S_RESP;
            S_RESP: begin
                rvalid_o  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        enter_resp = (state != S_RESP) && (state_nxt == S_RESP);
    end

    // Wait counter: runs only in WAIT and saturates rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)              wait_cnt <= '0;
        else if (state == S_WAIT) begin
            if (wait_cnt != 4'hF)  wait_cnt <= wait_cnt + 4'd1;
        end else                   wait_cnt <= '0;
    end

    // Capture the request on acceptance; inputs need not stay stable afterwards.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == S_IDLE && req_i) begin
            we_q    <= we_i;
            f3_q    <= funct3_i;
            addr_q  <= addr_i;
            wdata_q <= data_i;
        end
    end

    // Access decode: fault detection, byte enables, store lane replication, load extension.
    always_comb begin
        a_we   = (state == S_IDLE) ? we_i     : we_q;
        a_f3   = (state == S_IDLE) ? funct3_i : f3_q;
        a_addr = (state == S_IDLE) ? addr_i   : addr_q;
        a_data = (state == S_IDLE) ? data_i   : wdata_q;
        idx    = a_addr[IDX_W+1:2];
        lane   = a_addr[1:0];
        upper  = a_addr >> (IDX_W + 2);
        rword  = mem[idx];
        rbyte  = rword[{lane, 3'b000} +: 8];
        rhalf  = lane[1] ? rword[31:16] : rword[15:0];
        fault  = 1'b0;
        be     = 4'b0000;
        wword  = a_data;
        ldata  = '0;
        case (a_f3)
            3'b000: begin
                be    = 4'b0001 << lane;
                wword = {4{a_data[7:0]}};
                ldata = {{24{rbyte[7]}}, rbyte};
            end
            3'b001: begin
                fault = lane[0];
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{a_data[15:0]}};
                ldata = {{16{rhalf[15]}}, rhalf};
            end
            3'b010: begin
                fault = |lane;
                be    = 4'b1111;
                ldata = rword;
            end
            3'b100: begin
                fault = a_we;
                ldata = {24'd0, rbyte};
            end
            3'b101: begin
                fault = a_we | lane[0];
                ldata = {16'd0, rhalf};
            end
            default: fault = 1'b1;
        endcase
        if (|upper) fault = 1'b1;
    end

    // Store commit on the edge that enters RESP; no reset so the array can map to RAM.
    always_ff @(posedge clk_i) begin
        if (enter_resp && a_we && !fault)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
    end

    // Response registers: loaded on RESP entry from pre-store contents, held otherwise.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o <= '0;
            err_o  <= 1'b0;
        end else if (enter_resp) begin
            err_o  <= fault;
            data_o <= (fault || a_we) ? '0 : ldata;
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with three wait states.
module tb_data_mem_lsu;
    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, rvalid, err;
    logic [31:0] rdata;
    int          checks = 0;
    int          errors = 0;

    data_mem_lsu #(
        .DATA_WIDTH(32), .MEM_WORDS(1024), .ADDR_WIDTH(32), .WAIT_STATES(WS)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .funct3_i(f3),
        .addr_i(addr), .data_i(wdata), .ready_o(ready), .rvalid_o(rvalid),
        .data_o(rdata), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        er;
        logic        cd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, id, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e, input logic er, input logic cd);
        vec_t v;
        v.we = w; v.f3 = f; v.a = a; v.d = d; v.exp = e; v.er = er; v.cd = cd;
        tbl.push_back(v);
    endtask

    // Called at a negedge with ready high; returns at the negedge after the response.
    task automatic access(input int id, input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic re);
        int   lat;
        logic busy_ready;
        we = w; f3 = f; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        lat = 1;
        busy_ready = 1'b0;
        @(negedge clk);
        req = 1'b0; we = ~w; f3 = 3'b111; addr = 32'hFFFF_FFFC; wdata = 32'h5A5A_5A5A;
        while (!rvalid && lat < 40) begin
            if (ready) busy_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        rd = rdata;
        re = err;
        chk("latency", id, 32'(lat), 32'(WS + 1));
        chk("busy_ready", id, {31'd0, busy_ready}, 32'd0);
        @(negedge clk);
        chk("rvalid_one_cycle", id, {31'd0, rvalid}, 32'd0);
        chk("ready_after", id, {31'd0, ready}, 32'd1);
        chk("data_held", id, rdata, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        re;
        int          acc, rv;
        logic        saw;

        // Reset state.
        #1;
        chk("rst_ready", 0, {31'd0, ready}, 32'd1);
        chk("rst_rvalid", 0, {31'd0, rvalid}, 32'd0);
        chk("rst_data", 0, rdata, 32'd0);
        chk("rst_err", 0, {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //  we  f3      addr           data           expected      err  chkdata
        add(1, 3'b010, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,        0,   0);
        add(1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0,   0);
        add(0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0,  1);
        add(1, 3'b000, 32'h0000_0013, 32'h1234_5680, 32'h0,        0,   0);
        add(0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 0,  1);
        add(0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_0080, 0,  1);
        add(0, 3'b010, 32'h0000_0010, 32'h0,         32'h80AD_BEEF, 0,  1);
        add(1, 3'b010, 32'h0000_0020, 32'h1122_3344, 32'h0,        0,   0);
        add(1, 3'b001, 32'h0000_0022, 32'hABCD_8001, 32'h0,        0,   0);
        add(0, 3'b001, 32'h0000_0022, 32'h0,         32'hFFFF_8001, 0,  1);
        add(0, 3'b101, 32'h0000_0022, 32'h0,         32'h0000_8001, 0,  1);
        add(0, 3'b010, 32'h0000_0020, 32'h0,         32'h8001_3344, 0,  1);
        add(0, 3'b000, 32'h0000_0020, 32'h0,         32'h0000_0044, 0,  1);
        add(0, 3'b001, 32'h0000_0010, 32'h0,         32'hFFFF_BEEF, 0,  1);
        add(0, 3'b101, 32'h0000_0012, 32'h0,         32'h0000_80AD, 0,  1);
        add(0, 3'b100, 32'h0000_0011, 32'h0,         32'h0000_00BE, 0,  1);
        // Faults: data_o must be zero and nothing may be written.
        add(0, 3'b010, 32'h0000_0011, 32'h0,         32'h0,        1,   1);
        add(1, 3'b001, 32'h0000_0023, 32'h0000_FFFF, 32'h0,        1,   1);
        add(0, 3'b011, 32'h0000_0010, 32'h0,         32'h0,        1,   1);
        add(1, 3'b010, 32'h0000_1000, 32'h0000_0000, 32'h0,        1,   1);
        add(1, 3'b000, 32'h8000_0010, 32'h0000_0000, 32'h0,        1,   1);
        add(1, 3'b100, 32'h0000_0010, 32'h0000_0000, 32'h0,        1,   1);
        add(0, 3'b110, 32'h0000_0010, 32'h0,         32'h0,        1,   1);
        add(0, 3'b001, 32'h0000_0011, 32'h0,         32'h0,        1,   1);
        // Readback after the faulting accesses.
        add(0, 3'b010, 32'h0000_0010, 32'h0,         32'h80AD_BEEF, 0,  1);
        add(0, 3'b010, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 0,  1);
        add(0, 3'b010, 32'h0000_0020, 32'h0,         32'h8001_3344, 0,  1);
        add(0, 3'b000, 32'h0000_0012, 32'h0,         32'hFFFF_FFAD, 0,  1);

        foreach (tbl[i]) begin
            access(i, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].d, rd, re);
            chk("err", i, {31'd0, re}, {31'd0, tbl[i].er});
            if (tbl[i].cd) chk("data", i, rd, tbl[i].exp);
        end

        // req held high: one acceptance every WS+2 cycles, one rvalid per acceptance.
        acc = 0; rv = 0;
        we = 1'b0; f3 = 3'b010; addr = 32'h10; req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("hold_ready", i, {31'd0, ready}, {31'd0, (i % 5 == 0)});
            chk("hold_rvalid", i, {31'd0, rvalid}, {31'd0, (i % 5 == 4)});
            if (rvalid) chk("hold_data", i, rdata, 32'h80AD_BEEF);
            if (ready) acc++;
            if (rvalid) rv++;
            @(negedge clk);
        end
        req = 1'b0;
        chk("hold_accepts", 0, 32'(acc), 32'd4);
        chk("hold_rvalids", 0, 32'(rv), 32'd4);

        // Reset during WAIT abandons the store.
        access(100, 1'b1, 3'b010, 32'h40, 32'hA5A5_A5A5, rd, re);
        chk("rst_seed_err", 0, {31'd0, re}, 32'd0);
        we = 1'b1; f3 = 3'b010; addr = 32'h40; wdata = 32'h1234_5678; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("rst_busy", 0, {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 0, {31'd0, ready}, 32'd1);
        chk("rst_mid_rvalid", 0, {31'd0, rvalid}, 32'd0);
        chk("rst_mid_data", 0, rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rvalid) saw = 1'b1;
        end
        chk("rst_no_rvalid", 0, {31'd0, saw}, 32'd0);
        chk("rst_ready_after", 0, {31'd0, ready}, 32'd1);
        access(101, 1'b0, 3'b010, 32'h40, 32'h0, rd, re);
        chk("rst_readback", 0, rd, 32'hA5A5_A5A5);
        chk("rst_readback_err", 0, {31'd0, re}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
